// File: rtl/row_weight_loader.sv
// Run-time weight bank writer: packs M sign-magnitude words per row into S rows, with a combinational row-read port.
// Optional build macro WLOAD_NEGZERO_FIX_EN stores accepted negative-zero words as all-zeros.
module row_weight_loader #(
    parameter int M  = 8,
    parameter int S  = 8,
    parameter int n  = 16,
    parameter int AW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    input  logic [n-1:0]    in_data,
    output logic            in_ready,
    output logic            busy,
    output logic            done,
    output logic            loaded,
    output logic [AW-1:0]   row_idx,
    input  logic [AW-1:0]   rd_addr,
    output logic [M*n-1:0]  rd_W
);

    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam int RW = M * n;
    localparam int SW = (M - 1) * n;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   word_cnt_q, word_cnt_d;
    logic [AW-1:0]   row_idx_q, row_idx_d;
    logic [SW-1:0]   shift_q, shift_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            loaded_q, loaded_d;
    logic [RW-1:0]   bank_q [S];
    logic [RW-1:0]   bank_d [S];

    logic [n-1:0]    word_in;
    logic [RW-1:0]   row_word;

    always_comb begin
        word_in = in_data;
`ifdef WLOAD_NEGZERO_FIX_EN
        if (in_data == {1'b1, {(n-1){1'b0}}}) begin
            word_in = '0;
        end
`endif
        // Earlier words sit in the upper slots; the incoming word completes the bottom slot.
        row_word = {shift_q, word_in};
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        row_idx_d  = row_idx_q;
        shift_d    = shift_q;
        loaded_d   = loaded_q;
        bank_d     = bank_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    word_cnt_d = '0;
                    row_idx_d  = '0;
                    loaded_d   = 1'b0;
                end
            end
            LOAD: begin
                if (in_valid && in_ready_q) begin
                    shift_d = row_word[SW-1:0];
                    if (word_cnt_q == CW'(M - 1)) begin
                        word_cnt_d = '0;
                        for (int unsigned i = 0; i < S; i++) begin
                            if (row_idx_q == AW'(i)) begin
                                bank_d[i] = row_word;
                            end
                        end
                        if (row_idx_q == AW'(S - 1)) begin
                            row_idx_d = '0;
                            state_d   = DONE;
                        end else begin
                            row_idx_d = row_idx_q + AW'(1);
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + CW'(1);
                    end
                end
            end
            DONE: begin
                loaded_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == LOAD);
        busy_d     = (state_d == LOAD);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            row_idx_q  <= '0;
            shift_q    <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            loaded_q   <= 1'b0;
            bank_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            row_idx_q  <= row_idx_d;
            shift_q    <= shift_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            loaded_q   <= loaded_d;
            bank_q     <= bank_d;
        end
    end

    // Addresses at or beyond S fall through to the null row.
    always_comb begin
        rd_W = '0;
        for (int unsigned i = 0; i < S; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_W = bank_q[i];
            end
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign loaded   = loaded_q;
    assign row_idx  = row_idx_q;

endmodule
